student_iis_tx_stereo_fifo: RTL and testbench

- Parametrised stereo I2S transmitter; successor to the single-register FIR-output serializer.
- Accepts samples from the FIR output stage over a valid/ready stream tagged with a channel, and buffers them in per-channel FIFOs.
- Serialises each sample MSB-first into a configurable-width slot on AC_DAC_SDATA, in I2S (one-BCLK delay) or left-justified framing.
- Sits between the FIR datapath and the codec; uses LRCLK/BCLK edge strobes from the shared clock generator.

---
 rtl/student_iis_pkg.sv | 19 +
 rtl/student_iis_tx_fifo.sv | 53 +++++
 rtl/student_iis_tx_stereo_fifo.sv | 152 +++++++++++++++
 tb/tb_student_iis_tx_stereo_fifo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/student_iis_pkg.sv
// Shared types and constants for the stereo I2S transmitter.
//   iis_chan_e         : slot/FIFO channel select (left = 0, right = 1)
//   iis_mode_e         : serial framing (I2S one-BCLK delay, or left-justified)
//   IIS_UNDERRUN_CNT_W : width of the saturating underrun counter output
package student_iis_pkg;

  typedef enum logic {
    IIS_LEFT  = 1'b0,
    IIS_RIGHT = 1'b1
  } iis_chan_e;

  typedef enum logic {
    IIS_MODE_I2S = 1'b0,
    IIS_MODE_LJ  = 1'b1
  } iis_mode_e;

  localparam int IIS_UNDERRUN_CNT_W = 16;

endpackage

// File: rtl/student_iis_tx_fifo.sv
// Synchronous show-ahead FIFO, one instance per audio channel.
// The head entry is readable combinationally while empty is low.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (pointers cleared)
//   push, data    : write data into the tail (ignored while full)
//   pop           : discard the head entry (ignored while empty)
//   full, empty   : occupancy flags
//   head          : current head entry
module student_iis_tx_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit tells a full FIFO apart from an empty one.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset: an entry is only visible after it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data;
  end

endmodule

// File: rtl/student_iis_tx_stereo_fifo.sv
// Stereo I2S transmitter with per-channel sample FIFOs.
// Samples arrive from the FIR output stage tagged with a channel, are buffered
// per channel, and are serialised MSB-first into SLOT_W-bit slots on sdata_o.
// Slot starts come from the shared clock generator's LRCLK edge strobes, bit
// shifts from its BCLK falling-edge strobe.
// Optional build macro: STUDENT_IIS_TX_UNDERRUN_CNT_EN enables the saturating
// 16-bit underrun counter; otherwise underrun_cnt_o is tied to zero.
// Ports:
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   data_i, chan_i    : sample and its channel (0 = left, 1 = right)
//   valid_i, ready_o  : input stream handshake
//   mode_lj_i         : 0 = I2S framing, 1 = left-justified (sampled at slot start)
//   lrclk_rise_i      : right slot start strobe
//   lrclk_fall_i      : left slot start strobe (wins if both are high)
//   bclk_fall_i       : shift strobe
//   sdata_o           : serial data to the codec
//   underrun_o        : one-cycle pulse when a slot starts with an empty FIFO
//   underrun_cnt_o    : saturating underrun count (zero if feature disabled)
//
// Handshake: a sample transfers on a clock edge where valid_i && ready_o.
// ready_o is combinational from the full flag of the FIFO chan_i selects and
// does not depend on valid_i; a full FIFO refuses a push even if it pops in
// the same cycle.
module student_iis_tx_stereo_fifo
  import student_iis_pkg::*;
#(
  parameter int SAMPLE_W   = 24,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [SAMPLE_W-1:0]           data_i,
  input  logic                          chan_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic                          mode_lj_i,
  input  logic                          lrclk_rise_i,
  input  logic                          lrclk_fall_i,
  input  logic                          bclk_fall_i,
  output logic                          sdata_o,
  output logic                          underrun_o,
  output logic [IIS_UNDERRUN_CNT_W-1:0] underrun_cnt_o
);

  // The shift register holds one spare bit: the I2S delay bit ahead of the
  // sample, or a trailing zero in left-justified mode.
  localparam int SR_W  = SLOT_W + 1;
  localparam int EXT_W = SR_W - SAMPLE_W;

  logic [1:0]          push;
  logic [1:0]          pop;
  logic [1:0]          full;
  logic [1:0]          empty;
  logic [SAMPLE_W-1:0] head   [2];
  logic [SAMPLE_W-1:0] last_q [2];

  logic                slot_start;
  iis_chan_e           slot_chan;
  logic                slot_sel;
  iis_mode_e           mode;
  logic [SAMPLE_W-1:0] load_sample;
  logic [SR_W-1:0]     load_ext;
  logic [SR_W-1:0]     sr_q;
  logic [SR_W-1:0]     sr_d;
  logic                underrun_d;

  for (genvar c = 0; c < 2; c++) begin : g_fifo
    student_iis_tx_fifo #(
      .WIDTH (SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (push[c]),
      .data   (data_i),
      .pop    (pop[c]),
      .full   (full[c]),
      .empty  (empty[c]),
      .head   (head[c])
    );
  end

  assign ready_o    = ~full[chan_i];
  assign slot_start = lrclk_fall_i | lrclk_rise_i;
  assign slot_chan  = lrclk_fall_i ? IIS_LEFT : IIS_RIGHT;
  assign slot_sel   = slot_chan;
  assign mode       = mode_lj_i ? IIS_MODE_LJ : IIS_MODE_I2S;

  always_comb begin
    push = '0;
    if (valid_i && ready_o) push[chan_i] = 1'b1;
  end

  // Empty is the registered flag, so a push landing in an empty FIFO during
  // its own slot start is kept for the next slot rather than popped.
  always_comb begin
    pop        = '0;
    underrun_d = 1'b0;
    if (slot_start) begin
      if (empty[slot_sel]) underrun_d    = 1'b1;
      else                 pop[slot_sel] = 1'b1;
    end
  end

  // On underrun the channel repeats its last transmitted sample.
  assign load_sample = empty[slot_sel] ? last_q[slot_sel] : head[slot_sel];
  assign load_ext    = {{EXT_W{1'b0}}, load_sample};

  always_comb begin
    sr_d = sr_q;
    if (slot_start) begin
      if (mode == IIS_MODE_LJ) sr_d = load_ext << EXT_W;
      else                     sr_d = load_ext << (EXT_W - 1);
    end else if (bclk_fall_i) begin
      sr_d = {sr_q[SR_W-2:0], 1'b0};
    end
  end

  // sdata_o tracks the shift register MSB as a flop of its own, so it shows
  // the freshly loaded MSB right after a slot-start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q       <= '0;
      sdata_o    <= 1'b0;
      underrun_o <= 1'b0;
      for (int i = 0; i < 2; i++) last_q[i] <= '0;
    end else begin
      sr_q       <= sr_d;
      sdata_o    <= sr_d[SR_W-1];
      underrun_o <= underrun_d;
      if (pop[slot_sel]) last_q[slot_sel] <= head[slot_sel];
    end
  end

`ifdef STUDENT_IIS_TX_UNDERRUN_CNT_EN
  logic [IIS_UNDERRUN_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (underrun_d && (cnt_q != '1)) begin
      cnt_q <= cnt_q + IIS_UNDERRUN_CNT_W'(1);
    end
  end

  assign underrun_cnt_o = cnt_q;
`else
  assign underrun_cnt_o = '0;
`endif

endmodule

// File: tb/tb_student_iis_tx_stereo_fifo.sv
// Directed self-checking bench for student_iis_tx_stereo_fifo.
// Each slot is captured as the SLOT_W+1 values of sdata_o seen after the
// slot-start edge and after every following BCLK shift, MSB first, and is
// compared with the expected word taken from the scoreboard queue.
module tb_student_iis_tx_stereo_fifo;

  localparam int SAMPLE_W   = 24;
  localparam int SLOT_W     = 32;
  localparam int FIFO_DEPTH = 4;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic [SAMPLE_W-1:0] data_i = '0;
  logic                chan_i = 1'b0;
  logic                valid_i = 1'b0;
  logic                ready_o;
  logic                mode_lj_i = 1'b0;
  logic                lrclk_rise_i = 1'b0;
  logic                lrclk_fall_i = 1'b0;
  logic                bclk_fall_i = 1'b0;
  logic                sdata_o;
  logic                underrun_o;
  logic [15:0]         underrun_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  student_iis_tx_stereo_fifo #(
    .SAMPLE_W   (SAMPLE_W),
    .SLOT_W     (SLOT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .data_i         (data_i),
    .chan_i         (chan_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .mode_lj_i      (mode_lj_i),
    .lrclk_rise_i   (lrclk_rise_i),
    .lrclk_fall_i   (lrclk_fall_i),
    .bclk_fall_i    (bclk_fall_i),
    .sdata_o        (sdata_o),
    .underrun_o     (underrun_o),
    .underrun_cnt_o (underrun_cnt_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected slot words (SLOT_W+1 bits, MSB = first value after slot start).
  function automatic logic [63:0] i2s_word(input logic [SAMPLE_W-1:0] s);
    i2s_word = 64'(s) << (SLOT_W - SAMPLE_W);
  endfunction

  function automatic logic [63:0] lj_word(input logic [SAMPLE_W-1:0] s);
    lj_word = 64'(s) << (SLOT_W - SAMPLE_W + 1);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_sample(input logic chan, input logic [SAMPLE_W-1:0] d);
    chan_i  = chan;
    data_i  = d;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  // Runs one full slot; optionally pushes into the slot's own channel during
  // the slot-start cycle. Returns the number of underrun pulses observed.
  task automatic run_slot(input logic right, input logic push_en,
                          input logic [SAMPLE_W-1:0] push_data,
                          input string tag, output int uflow);
    logic [63:0] w;
    logic [63:0] exp;
    w     = '0;
    uflow = 0;
    lrclk_fall_i = !right;
    lrclk_rise_i = right;
    bclk_fall_i  = 1'b1;
    if (push_en) begin
      chan_i  = right;
      data_i  = push_data;
      valid_i = 1'b1;
    end
    tick();
    w = {w[62:0], sdata_o};
    if (underrun_o) uflow++;
    lrclk_fall_i = 1'b0;
    lrclk_rise_i = 1'b0;
    bclk_fall_i  = 1'b0;
    valid_i      = 1'b0;
    for (int i = 0; i < SLOT_W; i++) begin
      tick();
      if (underrun_o) uflow++;
      bclk_fall_i = 1'b1;
      tick();
      w = {w[62:0], sdata_o};
      if (underrun_o) uflow++;
      bclk_fall_i = 1'b0;
    end
    check_eq({tag, "_sb_avail"}, 64'(exp_q.size() != 0), 64'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check_eq(tag, w, exp);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] cnt_exp;
  int          uf;

  initial begin
    // Reset state
    tick();
    tick();
    check_eq("rst_sdata", 64'(sdata_o), 64'd0);
    check_eq("rst_underrun", 64'(underrun_o), 64'd0);
    check_eq("rst_cnt", 64'(underrun_cnt_o), 64'd0);
    chan_i = 1'b0; #1;
    check_eq("rst_ready_l", 64'(ready_o), 64'd1);
    chan_i = 1'b1; #1;
    check_eq("rst_ready_r", 64'(ready_o), 64'd1);
    rst_ni = 1'b1;
    tick();

    // I2S framing, both channels
    push_sample(1'b0, 24'hA5A5A5);
    push_sample(1'b1, 24'h123456);
    exp_q.push_back(i2s_word(24'hA5A5A5));
    run_slot(1'b0, 1'b0, '0, "i2s_left", uf);
    check_eq("i2s_left_uf", 64'(uf), 64'd0);
    exp_q.push_back(i2s_word(24'h123456));
    run_slot(1'b1, 1'b0, '0, "i2s_right", uf);
    check_eq("i2s_right_uf", 64'(uf), 64'd0);

    // Left-justified framing
    mode_lj_i = 1'b1;
    push_sample(1'b0, 24'hA5A5A5);
    push_sample(1'b1, 24'h123456);
    exp_q.push_back(lj_word(24'hA5A5A5));
    run_slot(1'b0, 1'b0, '0, "lj_left", uf);
    check_eq("lj_left_uf", 64'(uf), 64'd0);
    exp_q.push_back(lj_word(24'h123456));
    run_slot(1'b1, 1'b0, '0, "lj_right", uf);
    check_eq("lj_right_uf", 64'(uf), 64'd0);
    mode_lj_i = 1'b0;

    // Fill left FIFO, check back-pressure and rejected push
    push_sample(1'b0, 24'h111111);
    push_sample(1'b0, 24'h222222);
    push_sample(1'b0, 24'h333333);
    push_sample(1'b0, 24'h00000F);
    chan_i = 1'b0; #1;
    check_eq("full_ready_l", 64'(ready_o), 64'd0);
    chan_i = 1'b1; #1;
    check_eq("full_ready_r", 64'(ready_o), 64'd1);
    push_sample(1'b0, 24'hDEAD00);
    exp_q.push_back(i2s_word(24'h111111));
    exp_q.push_back(i2s_word(24'h222222));
    exp_q.push_back(i2s_word(24'h333333));
    exp_q.push_back(i2s_word(24'h00000F));
    for (int k = 0; k < 4; k++) begin
      run_slot(1'b0, 1'b0, '0, $sformatf("fill_slot%0d", k), uf);
      check_eq($sformatf("fill_slot%0d_uf", k), 64'(uf), 64'd0);
    end

    // Underrun: hold-last retransmission
    exp_q.push_back(i2s_word(24'h00000F));
    run_slot(1'b0, 1'b0, '0, "under_left", uf);
    check_eq("under_left_uf", 64'(uf), 64'd1);
`ifdef STUDENT_IIS_TX_UNDERRUN_CNT_EN
    cnt_exp = 16'd1;
`else
    cnt_exp = 16'd0;
`endif
    check_eq("under_cnt1", 64'(underrun_cnt_o), 64'(cnt_exp));

    // Push into the empty FIFO during its own slot start
    exp_q.push_back(i2s_word(24'h00000F));
    run_slot(1'b0, 1'b1, 24'h777777, "same_cycle_push", uf);
    check_eq("same_cycle_push_uf", 64'(uf), 64'd1);
`ifdef STUDENT_IIS_TX_UNDERRUN_CNT_EN
    cnt_exp = 16'd2;
`endif
    check_eq("under_cnt2", 64'(underrun_cnt_o), 64'(cnt_exp));
    exp_q.push_back(i2s_word(24'h777777));
    run_slot(1'b0, 1'b0, '0, "stored_push", uf);
    check_eq("stored_push_uf", 64'(uf), 64'd0);

    // Asynchronous reset mid-slot after 10 shifts
    push_sample(1'b0, 24'hFFFFFF);
    push_sample(1'b1, 24'hFFFFFF);
    lrclk_fall_i = 1'b1;
    bclk_fall_i  = 1'b1;
    tick();
    lrclk_fall_i = 1'b0;
    bclk_fall_i  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      bclk_fall_i = 1'b1;
      tick();
      bclk_fall_i = 1'b0;
    end
    check_eq("mid_sdata", 64'(sdata_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    check_eq("arst_sdata", 64'(sdata_o), 64'd0);
    check_eq("arst_cnt", 64'(underrun_cnt_o), 64'd0);
    chan_i = 1'b0; #1;
    check_eq("arst_ready_l", 64'(ready_o), 64'd1);
    chan_i = 1'b1; #1;
    check_eq("arst_ready_r", 64'(ready_o), 64'd1);
    tick();
    rst_ni = 1'b1;
    tick();
    exp_q.push_back(64'd0);
    run_slot(1'b0, 1'b0, '0, "post_rst_left", uf);
    check_eq("post_rst_left_uf", 64'(uf), 64'd1);
    exp_q.push_back(64'd0);
    run_slot(1'b1, 1'b0, '0, "post_rst_right", uf);
    check_eq("post_rst_right_uf", 64'(uf), 64'd1);

    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
